ct_pmp_csr_ctrl: RTL
====================

# ct_pmp_csr_ctrl

CP0-side initiator for the PMP CSR port: accepts one PMP CSR instruction at a time (CSRRW/CSRRS/CSRRC on pmpcfg0/2 or pmpaddr0–15). It performs the architectural read-modify-write by driving the PMP unit's register-number, write-strobe and write-data inputs, and sampling its combinational read data. It returns the old CSR value, or an illegal-CSR error, to the CP0 retire logic through a valid/ready response.

## Interface
Parameters: none. PMP width fixed at 64-bit data, 5-bit register number.

- forever_cpuclk  in  1  free-running core clock
- cpurst  in  1  reset, asynchronous, active-high
- req_vld  in  1  CSR request valid
- req_rdy  out  1  request accepted when req_vld & req_rdy
- req_op  in  2  00 RW, 01 RS, 10 RC, 11 reserved (error)
- req_reg_num  in  5  CSR address bits [4:0] within 0x3A0–0x3BF
- req_wdata  in  64  rs1/immediate operand
- req_nowr  in  1  source is x0/zero-imm; suppresses write for RS/RC only
- flush  in  1  pipeline flush; aborts an uncommitted request
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response consumed when rsp_vld & rsp_rdy
- rsp_data  out  64  old CSR value (0 on error)
- rsp_err  out  1  illegal CSR / reserved op
- cp0_pmp_reg_num  out  5  register select to PMP unit
- cp0_pmp_wreg  out  1  single-cycle write strobe to PMP unit
- cp0_pmp_wdata  out  64  write data to PMP unit
- pmp_cp0_data  in  64  combinational read data from PMP unit for cp0_pmp_reg_num

## Operation
- Legal reg_num: 5'h00 (pmpcfg0), 5'h02 (pmpcfg2), 5'h10–5'h1F (pmpaddr0–15). All others, and op 11, are errors.
- FSM states IDLE, READ, WRITE, RESP.
- IDLE: req_rdy=1. On accept, latch op/reg_num/wdata/nowr. Illegal → RESP with rsp_err=1, rsp_data=0. Legal → READ.
- READ: cp0_pmp_reg_num = latched reg_num. At the clock edge, capture pmp_cp0_data into old. Compute new: RW → wdata; RS → old | wdata; RC → old & ~wdata. Write needed = RW, or (RS/RC and !nowr). If needed → WRITE, else RESP.
- WRITE: cp0_pmp_wreg=1 for exactly this cycle; cp0_pmp_wdata=new; reg_num held. Always → RESP. The PMP unit owns WARL/lock filtering; this block never masks data.
- RESP: rsp_vld=1, rsp_data=old, rsp_err as latched. Hold until rsp_rdy, then → IDLE.
- flush: in READ, return to IDLE with no write and no response. In WRITE and RESP, ignore (write committed; response still delivered). In IDLE, block accept that cycle.

## Timing
- Reset: state IDLE; req_rdy=1; rsp_vld=0, rsp_err=0, rsp_data=0; cp0_pmp_wreg=0, cp0_pmp_wdata=0, cp0_pmp_reg_num=0.
- Accept at edge 0. READ occupies cycle 1. WRITE occupies cycle 2; rsp_vld in cycle 3. With no write, rsp_vld in cycle 2. On error, rsp_vld in cycle 1.
- cp0_pmp_wreg is registered. It is never asserted outside WRITE, and never for two consecutive cycles.
- cp0_pmp_reg_num and cp0_pmp_wdata hold their last values in IDLE/RESP. wreg=0 there, so this is harmless.
- req_rdy=0 outside IDLE. There is no back-to-back accept from RESP; the next accept is earliest the cycle after the handshake.
- rsp_data/rsp_err are stable while rsp_vld & !rsp_rdy.

## Structure
- Shared package/header ct_pmp_csr_pkg: op encodings, legal reg_num constants (CFG0=5'h00, CFG2=5'h02, ADDR_BASE=5'h10), state encoding.
- One sub-module, ct_pmp_csr_dec: combinational legality check plus new-value ALU. The FSM and registers live in the top.

## Test plan
- CSRRW pmpaddr3 (reg 5'h13), wdata 0x1234, PMP model holds 0xAAAA → wreg pulses in cycle 2 with wdata 0x1234; rsp_data=0xAAAA, rsp_err=0 in cycle 3.
- CSRRS pmpcfg0, old 0x0F, wdata 0xF0 → wdata 0xFF. CSRRC with wdata 0x0F on old 0xFF → wdata 0xF0.
- CSRRS pmpcfg2 with req_nowr=1 → no wreg; rsp_vld in cycle 2 with old value. CSRRW with req_nowr=1 still writes.
- reg_num 5'h01, 5'h03 and 5'h0F, plus op 11 → rsp_err=1, rsp_data=0, rsp_vld in cycle 1, wreg never asserted.
- flush during READ → no wreg, no rsp_vld, req_rdy=1 next cycle. flush during WRITE → write and response both complete.
- rsp_rdy held low 5 cycles → rsp_vld/rsp_data stable, req_rdy=0 throughout. Assert cpurst mid-WRITE → all outputs return to reset values immediately.

Source files
------------

// File: rtl/ct_pmp_csr_pkg.sv
// Shared types and constants for the CP0-side PMP CSR initiator.
// Op encodings, legal register numbers and FSM state encoding.
package ct_pmp_csr_pkg;

  localparam int DW = 64;
  localparam int RW = 5;

  typedef enum logic [1:0] {
    OP_RW  = 2'b00,
    OP_RS  = 2'b01,
    OP_RC  = 2'b10,
    OP_RSV = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [RW-1:0] CFG0      = 5'h00;
  localparam logic [RW-1:0] CFG2      = 5'h02;
  localparam logic [RW-1:0] ADDR_BASE = 5'h10;

  // pmpaddr0-15 occupy the upper half of the 5-bit space
  function automatic logic reg_legal(input logic [RW-1:0] r);
    return (r == CFG0) || (r == CFG2) ||
           ((r & ADDR_BASE) == ADDR_BASE);
  endfunction

endpackage

// File: rtl/ct_pmp_csr_dec.sv
// Legality check for an incoming PMP CSR request and the
// read-modify-write value computation for the latched one.
module ct_pmp_csr_dec
  import ct_pmp_csr_pkg::*;
(
  input  logic [1:0]    chk_op_i,
  input  logic [RW-1:0] chk_reg_i,
  input  logic [1:0]    alu_op_i,
  input  logic [DW-1:0] alu_wdata_i,
  input  logic          alu_nowr_i,
  input  logic [DW-1:0] alu_old_i,
  output logic          legal_o,
  output logic [DW-1:0] new_o,
  output logic          wen_o
);

  logic op_rw;
  logic op_rs;
  logic op_rc;

  assign legal_o = reg_legal(chk_reg_i) &&
                   (chk_op_i != OP_RSV);

  assign op_rw = (alu_op_i == OP_RW);
  assign op_rs = (alu_op_i == OP_RS);
  assign op_rc = (alu_op_i == OP_RC);

  always_comb begin
    new_o = alu_old_i;
    wen_o = 1'b0;
    unique case (1'b1)
      op_rw: begin
        new_o = alu_wdata_i;
        wen_o = 1'b1;
      end
      op_rs: begin
        new_o = alu_old_i | alu_wdata_i;
        wen_o = ~alu_nowr_i;
      end
      op_rc: begin
        new_o = alu_old_i & ~alu_wdata_i;
        wen_o = ~alu_nowr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ct_pmp_csr_ctrl.sv
// CP0-side PMP CSR initiator: one CSRRW/RS/RC at a time,
// read-modify-write over the PMP register port, valid/ready response.
module ct_pmp_csr_ctrl
  import ct_pmp_csr_pkg::*;
(
  input  logic          forever_cpuclk,
  input  logic          cpurst,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic [1:0]    req_op,
  input  logic [RW-1:0] req_reg_num,
  input  logic [DW-1:0] req_wdata,
  input  logic          req_nowr,
  input  logic          flush,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [RW-1:0] cp0_pmp_reg_num,
  output logic          cp0_pmp_wreg,
  output logic [DW-1:0] cp0_pmp_wdata,
  input  logic [DW-1:0] pmp_cp0_data
);

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [RW-1:0] reg_q, reg_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          nowr_q, nowr_d;
  logic          err_q, err_d;
  logic [DW-1:0] old_q, old_d;
  logic          wreg_q, wreg_d;
  logic [DW-1:0] pwdata_q, pwdata_d;

  logic          legal;
  logic [DW-1:0] new_val;
  logic          wen;
  logic          accept;

  ct_pmp_csr_dec u_dec (
    .chk_op_i    (req_op),
    .chk_reg_i   (req_reg_num),
    .alu_op_i    (op_q),
    .alu_wdata_i (wdata_q),
    .alu_nowr_i  (nowr_q),
    .alu_old_i   (pmp_cp0_data),
    .legal_o     (legal),
    .new_o       (new_val),
    .wen_o       (wen)
  );

  assign req_rdy = (state_q == ST_IDLE) & ~flush;
  assign accept  = req_vld & req_rdy;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    nowr_d   = nowr_q;
    err_d    = err_q;
    old_d    = old_q;
    wreg_d   = 1'b0;
    pwdata_d = pwdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = req_op;
          reg_d   = req_reg_num;
          wdata_d = req_wdata;
          nowr_d  = req_nowr;
          if (legal) begin
            err_d   = 1'b0;
            state_d = ST_READ;
          end else begin
            err_d   = 1'b1;
            old_d   = '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_READ: begin
        // flush is only honoured before the write commits
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          old_d = pmp_cp0_data;
          if (wen) begin
            pwdata_d = new_val;
            wreg_d   = 1'b1;
            state_d  = ST_WRITE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      reg_q    <= '0;
      wdata_q  <= '0;
      nowr_q   <= 1'b0;
      err_q    <= 1'b0;
      old_q    <= '0;
      wreg_q   <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      nowr_q   <= nowr_d;
      err_q    <= err_d;
      old_q    <= old_d;
      wreg_q   <= wreg_d;
      pwdata_q <= pwdata_d;
    end
  end

  assign rsp_vld         = (state_q == ST_RESP);
  assign rsp_data        = old_q;
  assign rsp_err         = err_q;
  assign cp0_pmp_reg_num = reg_q;
  assign cp0_pmp_wreg    = wreg_q;
  assign cp0_pmp_wdata   = pwdata_q;

endmodule
